// File: rtl/sfa_bram_pkg.sv
// Shared constants, FSM encoding and byte-lane helper for the SFA BRAM responder.
package sfa_bram_pkg;

  localparam int WM_READ_FIRST  = 0;
  localparam int WM_WRITE_FIRST = 1;
  localparam int WM_NO_CHANGE   = 2;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Replace only the byte lanes whose write-enable bit is set.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  we);
    logic [31:0] res;
    res = old_w;
    for (int k = 0; k < 4; k++) begin
      if (we[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sfa_bram_rdpipe.sv
// Tagged read-return pipeline: READ_LAT-1 shift stages feeding an output register
// that only loads when the arriving entry is tagged.
module sfa_bram_rdpipe #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  input  logic [31:0] in_data,
  output logic [31:0] dout
);

  logic        tail_vld;
  logic [31:0] tail_data;

  generate
    if (READ_LAT == 1) begin : g_direct
      assign tail_vld  = in_vld;
      assign tail_data = in_data;
    end else begin : g_stages
      localparam int N = READ_LAT - 1;
      logic        vld_p  [N];
      logic [31:0] data_p [N];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < N; i++) vld_p[i] <= 1'b0;
        end else begin
          vld_p[0] <= in_vld;
          for (int i = 1; i < N; i++) vld_p[i] <= vld_p[i-1];
        end
      end

      always_ff @(posedge clk) begin
        data_p[0] <= in_data;
        for (int i = 1; i < N; i++) data_p[i] <= data_p[i-1];
      end

      assign tail_vld  = vld_p[N-1];
      assign tail_data = data_p[N-1];
    end
  endgenerate

  // Output stage: hold the last returned word across untagged slots.
  always_ff @(posedge clk) begin
    if (rst)           dout <= '0;
    else if (tail_vld) dout <= tail_data;
  end

endmodule

// File: rtl/sfa_bram_resp.sv
// Single-port BRAM responder: DEPTH x 32-bit store with byte-lane writes,
// post-reset clear sequence, fixed-latency read return and access statistics.
module sfa_bram_resp
  import sfa_bram_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int READ_LAT   = 1,
  parameter int WRITE_MODE = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic        bram_clk,
  input  logic        bram_rst,
  input  logic        bram_en,
  input  logic [3:0]  bram_we,
  input  logic [31:0] bram_addr,
  input  logic [31:0] bram_din,
  output logic [31:0] bram_dout,
  output logic        init_busy,
  output logic        oob_err,
  output logic        busy_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  input  logic        clr_stats
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIM = 32'(DEPTH * 4);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [31:0] mem [DEPTH];

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            clr_we;

  always_ff @(posedge bram_clk) begin
    if (bram_rst) begin
      state_q   <= (INIT_CLEAR != 0) ? ST_INIT : ST_READY;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we    = 1'b0;
    case (state_q)
      ST_INIT: begin
        clr_we    = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == AW'(DEPTH - 1)) state_d = ST_READY;
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_READY;
    endcase
  end

  assign init_busy = (state_q == ST_INIT);

  logic          in_range, is_wr, acc, busy_hit;
  logic [AW-1:0] idx;
  logic [31:0]   old_w, new_w;

  assign in_range = (bram_addr < ADDR_LIM);
  assign idx      = bram_addr[AW+1:2];
  assign is_wr    = |bram_we;
  assign acc      = bram_en & ~bram_rst & (state_q == ST_READY);
  assign busy_hit = bram_en & ~bram_rst & (state_q == ST_INIT);
  assign old_w    = in_range ? mem[idx] : '0;
  assign new_w    = lane_merge(old_w, bram_din, bram_we);

  always_ff @(posedge bram_clk) begin
    if (clr_we)                          mem[clr_idx_q] <= '0;
    else if (acc && is_wr && in_range)   mem[idx]       <= new_w;
  end

  // Issue stage: tag and capture the word that the access returns.
  logic        pipe_vld_p0;
  logic [31:0] pipe_data_p0;

  assign pipe_vld_p0  = acc & (~is_wr | (WRITE_MODE != WM_NO_CHANGE));
  assign pipe_data_p0 = (is_wr && (WRITE_MODE == WM_WRITE_FIRST) && in_range) ? new_w : old_w;

  sfa_bram_rdpipe #(.READ_LAT(READ_LAT)) u_rdpipe (
    .clk     (bram_clk),
    .rst     (bram_rst),
    .in_vld  (pipe_vld_p0),
    .in_data (pipe_data_p0),
    .dout    (bram_dout)
  );

  logic rd_hit, wr_hit, oob_hit;

  assign rd_hit  = acc & ~is_wr & in_range;
  assign wr_hit  = acc &  is_wr & in_range;
  assign oob_hit = acc & ~in_range;

  // A same-cycle clear discards the event that would otherwise be recorded.
  always_ff @(posedge bram_clk) begin
    if (bram_rst || clr_stats) begin
      rd_count <= '0;
      wr_count <= '0;
      oob_err  <= 1'b0;
      busy_err <= 1'b0;
    end else begin
      if (rd_hit)   rd_count <= sat_inc(rd_count);
      if (wr_hit)   wr_count <= sat_inc(wr_count);
      if (oob_hit)  oob_err  <= 1'b1;
      if (busy_hit) busy_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sfa_bram_resp.sv
// Bench for sfa_bram_resp: three instances (read-first/lat1, write-first/lat1,
// no-change/lat3) against a memory-level reference model, plus directed literals.
module tb_sfa_bram_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  we = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] din = 32'd0;
  logic        clr = 1'b0;

  logic [31:0] dout [3];
  logic        ibusy [3];
  logic        oob [3];
  logic        berr [3];
  logic [15:0] rdc [3];
  logic [15:0] wrc [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sfa_bram_resp #(.DEPTH(16), .READ_LAT(1), .WRITE_MODE(0), .INIT_CLEAR(1)) u0 (
    .bram_clk(clk), .bram_rst(rst), .bram_en(en), .bram_we(we), .bram_addr(addr),
    .bram_din(din), .bram_dout(dout[0]), .init_busy(ibusy[0]), .oob_err(oob[0]),
    .busy_err(berr[0]), .rd_count(rdc[0]), .wr_count(wrc[0]), .clr_stats(clr));

  sfa_bram_resp #(.DEPTH(16), .READ_LAT(1), .WRITE_MODE(1), .INIT_CLEAR(1)) u1 (
    .bram_clk(clk), .bram_rst(rst), .bram_en(en), .bram_we(we), .bram_addr(addr),
    .bram_din(din), .bram_dout(dout[1]), .init_busy(ibusy[1]), .oob_err(oob[1]),
    .busy_err(berr[1]), .rd_count(rdc[1]), .wr_count(wrc[1]), .clr_stats(clr));

  sfa_bram_resp #(.DEPTH(16), .READ_LAT(3), .WRITE_MODE(2), .INIT_CLEAR(1)) u2 (
    .bram_clk(clk), .bram_rst(rst), .bram_en(en), .bram_we(we), .bram_addr(addr),
    .bram_din(din), .bram_dout(dout[2]), .init_busy(ibusy[2]), .oob_err(oob[2]),
    .busy_err(berr[2]), .rd_count(rdc[2]), .wr_count(wrc[2]), .clr_stats(clr));

  function automatic int lat_of(input int i);
    return (i == 2) ? 3 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: memory contents, words left to clear, stats, and the
  // result history that lands on dout READ_LAT sample edges after issue.
  logic [31:0] m_mem [3][16];
  int          m_clr_left [3];
  logic [15:0] m_rd [3];
  logic [15:0] m_wr [3];
  logic        m_oob [3];
  logic        m_busy [3];
  logic [31:0] m_dout [3];
  logic        h_vld [3][2];
  logic [31:0] h_data [3][2];
  bit          live = 1'b0;

  task automatic model_step(input int i);
    logic        rv, inr, ev_rd, ev_wr, ev_oob, ev_busy, outv;
    logic [31:0] rdat, old, mrg, outd;
    if (rst) begin
      m_clr_left[i] = 16;
      m_rd[i] = 16'd0; m_wr[i] = 16'd0; m_oob[i] = 1'b0; m_busy[i] = 1'b0;
      m_dout[i] = 32'd0;
      for (int s = 0; s < 2; s++) begin h_vld[i][s] = 1'b0; h_data[i][s] = 32'd0; end
      return;
    end
    rv = 1'b0; rdat = 32'd0;
    ev_rd = 1'b0; ev_wr = 1'b0; ev_oob = 1'b0; ev_busy = 1'b0;
    if (m_clr_left[i] > 0) begin
      m_mem[i][16 - m_clr_left[i]] = 32'd0;
      m_clr_left[i] = m_clr_left[i] - 1;
      ev_busy = en;
    end else if (en) begin
      inr = (addr < 32'd64);
      old = inr ? m_mem[i][addr[5:2]] : 32'd0;
      mrg = old;
      for (int b = 0; b < 4; b++) if (we[b]) mrg[8*b +: 8] = din[8*b +: 8];
      if (we != 4'd0) begin
        if (inr) begin m_mem[i][addr[5:2]] = mrg; ev_wr = 1'b1; end
        else ev_oob = 1'b1;
        rv   = (i != 2);
        rdat = !inr ? 32'd0 : (i == 1) ? mrg : old;
      end else begin
        rv = 1'b1; rdat = old;
        if (inr) ev_rd = 1'b1; else ev_oob = 1'b1;
      end
    end
    if (clr) begin
      m_rd[i] = 16'd0; m_wr[i] = 16'd0; m_oob[i] = 1'b0; m_busy[i] = 1'b0;
    end else begin
      if (ev_rd && m_rd[i] != 16'hFFFF) m_rd[i] = m_rd[i] + 16'd1;
      if (ev_wr && m_wr[i] != 16'hFFFF) m_wr[i] = m_wr[i] + 16'd1;
      if (ev_oob)  m_oob[i]  = 1'b1;
      if (ev_busy) m_busy[i] = 1'b1;
    end
    if (lat_of(i) == 1) begin outv = rv; outd = rdat; end
    else begin outv = h_vld[i][lat_of(i)-2]; outd = h_data[i][lat_of(i)-2]; end
    h_vld[i][1] = h_vld[i][0]; h_data[i][1] = h_data[i][0];
    h_vld[i][0] = rv;          h_data[i][0] = rdat;
    if (outv) m_dout[i] = outd;
  endtask

  always @(posedge clk) begin
    if (rst) live = 1'b1;
    for (int i = 0; i < 3; i++) model_step(i);
  end

  always @(negedge clk) begin
    if (live) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d dout", i), dout[i], m_dout[i]);
        chk($sformatf("u%0d init_busy", i), {31'd0, ibusy[i]}, {31'd0, m_clr_left[i] > 0});
        chk($sformatf("u%0d oob_err", i), {31'd0, oob[i]}, {31'd0, m_oob[i]});
        chk($sformatf("u%0d busy_err", i), {31'd0, berr[i]}, {31'd0, m_busy[i]});
        chk($sformatf("u%0d rd_count", i), {16'd0, rdc[i]}, {16'd0, m_rd[i]});
        chk($sformatf("u%0d wr_count", i), {16'd0, wrc[i]}, {16'd0, m_wr[i]});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = 1'b1; we = w; addr = a; din = d;
    cyc();
  endtask

  task automatic idle();
    en = 1'b0; we = 4'd0;
    cyc();
  endtask

  task automatic count_busy(output int n, input bit poke);
    n = 0;
    while (ibusy[0] && n < 100) begin
      en = poke && (n == 2);
      n++;
      cyc();
    end
    en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    cyc();
    rst = 1'b0;
    chk("reset init_busy", {31'd0, ibusy[0]}, 32'd1);
    chk("reset dout", dout[0], 32'd0);
    chk("reset rd_count", {16'd0, rdc[0]}, 32'd0);

    // Clear sequence with one access attempted mid-clear.
    count_busy(n, 1'b1);
    chk("clear length", n, 32'd16);
    chk("busy_err set", {31'd0, berr[0]}, 32'd1);
    chk("busy no count", {16'd0, rdc[0]}, 32'd0);
    clr = 1'b1; idle(); clr = 1'b0;
    chk("busy_err cleared", {31'd0, berr[0]}, 32'd0);

    for (int a = 0; a < 16; a++) begin
      acc(4'd0, 32'(a * 4), 32'd0);
      chk("cleared word", dout[0], 32'd0);
    end
    chk("sweep rd_count", {16'd0, rdc[0]}, 32'd16);

    // Streaming reads after two writes.
    clr = 1'b1; idle(); clr = 1'b0;
    acc(4'hF, 32'h00, 32'h11111111);
    acc(4'hF, 32'h04, 32'h22222222);
    acc(4'd0, 32'h00, 32'd0);
    chk("stream rd0", dout[0], 32'h11111111);
    acc(4'd0, 32'h04, 32'd0);
    chk("stream rd1", dout[0], 32'h22222222);
    idle(); idle();
    chk("dout hold", dout[0], 32'h22222222);
    chk("stream rd_count", {16'd0, rdc[0]}, 32'd2);
    chk("stream wr_count", {16'd0, wrc[0]}, 32'd2);

    // Byte lanes and write modes.
    acc(4'hF, 32'h08, 32'hAABBCCDD);
    acc(4'b0101, 32'h08, 32'h11223344);
    chk("mode0 dout", dout[0], 32'hAABBCCDD);
    chk("mode1 dout", dout[1], 32'hAA22CC44);
    chk("mode2 dout", dout[2], 32'h22222222);
    acc(4'd0, 32'h08, 32'd0);
    chk("merged word", dout[0], 32'hAA22CC44);

    // Out of range.
    acc(4'hF, 32'h40, 32'hDEADBEEF);
    chk("oob_err", {31'd0, oob[0]}, 32'd1);
    chk("oob wr_count", {16'd0, wrc[0]}, 32'd4);
    acc(4'd0, 32'h00, 32'd0);
    chk("no alias", dout[0], 32'h11111111);
    acc(4'd0, 32'h40, 32'd0);
    chk("oob read", dout[0], 32'd0);
    chk("oob rd_count", {16'd0, rdc[0]}, 32'd4);

    // READ_LAT=3 timing on u2.
    for (int k = 0; k < 4; k++) idle();
    acc(4'd0, 32'h08, 32'd0);
    en = 1'b0;
    chk("lat3 +1", dout[2], 32'd0);
    idle();
    chk("lat3 +2", dout[2], 32'd0);
    idle();
    chk("lat3 +3", dout[2], 32'hAA22CC44);

    // Clear beats a same-cycle read, then saturation.
    clr = 1'b1; acc(4'd0, 32'h00, 32'd0); clr = 1'b0;
    chk("clr wins", {16'd0, rdc[0]}, 32'd0);
    for (int k = 0; k < 65535; k++) acc(4'd0, 32'h04, 32'd0);
    chk("rd sat", {16'd0, rdc[0]}, 32'hFFFF);
    acc(4'd0, 32'h04, 32'd0);
    chk("rd sat hold", {16'd0, rdc[0]}, 32'hFFFF);
    idle();
    chk("wr untouched", {16'd0, wrc[0]}, 32'd0);

    // Reset mid-clear restarts at word 0.
    rst = 1'b1; idle(); rst = 1'b0;
    for (int k = 0; k < 5; k++) idle();
    rst = 1'b1; idle(); rst = 1'b0;
    chk("rst dout", dout[0], 32'd0);
    chk("rst dout lat3", dout[2], 32'd0);
    chk("rst rd_count", {16'd0, rdc[0]}, 32'd0);
    count_busy(n, 1'b0);
    chk("reclear length", n, 32'd16);
    acc(4'd0, 32'h08, 32'd0);
    chk("reclear word", dout[0], 32'd0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
